status_vector_ctrl: RTL and testbench
=====================================

// Module: status_vector_ctrl
// PURPOSE
//  Sequencer for the DEPTH-entry status valid vector. Round-robin arbitrates REQS
//  push requesters into at most one push per cycle, qualifies commit pulls, and
//  owns occupancy: count, full/empty and the thermometer update mask (tail
//  pointer) driven into every per-bit update cell. Also runs the flush/drain FSM.
// PARAMETERS
//  DEPTH  8  entries in the status vector (>=2)
//  REQS   4  push requesters (>=1); CW = $clog2(DEPTH+1) derived locally
// PORTS
//  clk_i     in   1      clock, rising edge
//  arst_n_i  in   1      asynchronous active-low reset
//  en_i      in   1      leave IDLE and start accepting traffic
//  req_i     in   REQS   push request per requester
//  value_i   in   REQS   status bit offered by each requester
//  gnt_o     out  REQS   one-hot grant (comb); push accepted this cycle
//  commit_i  in   1      request to pull (retire) head entry [0]
//  flush_i   in   1      start drain of all entries
//  push_o    out  1      push to status vector (comb)
//  pull_o    out  1      pull to status vector (comb)
//  value_o   out  1      value_i of granted requester, 0 when no grant
//  mask_o    out  DEPTH  registered thermometer: bit i=1 iff entry i occupied
//  count_o   out  CW     registered occupancy 0..DEPTH
//  full_o    out  1      count_o==DEPTH;  empty_o out 1  count_o==0
//  busy_o    out  1      1 in FLUSH
//  hwm_o     out  CW     occupancy high-water mark (feature)
//  stall_o   out  16     saturating count of refused push cycles (feature)
// BEHAVIOUR
//  - Reset: state IDLE, mask_o=0, count_o=0, empty_o=1, full_o=0, rr pointer=0,
//    hwm_o=0, stall_o=0; comb outputs 0 as state is IDLE.
//  - FSM: IDLE -en_i-> RUN; RUN -flush_i-> FLUSH (flush_i wins over pushes that
//    cycle: no grant); FLUSH -empty_o-> IDLE. flush_i ignored in IDLE/FLUSH.
//  - IDLE: gnt_o=0, push_o=0, pull_o=0; commit_i/req_i ignored.
//  - RUN pull: pull_o = commit_i & ~empty_o.
//  - RUN push: can_push = ~full_o | pull_o; push_o = |req_i & can_push & ~flush_i.
//    Full with simultaneous commit -> push and pull same cycle (count unchanged).
//    Empty with push and commit -> push only, commit dropped.
//  - Arbiter: round-robin from pointer p; first asserted req at index >= p
//    (wrap) granted; after a grant p <= grant_idx+1 mod REQS; no grant, p holds.
//    Single requester: granted every acceptable cycle.
//  - FLUSH: gnt_o=0, push_o=0, pull_o=~empty_o (one entry per cycle), busy_o=1.
//  - Update (all same edge): push&~pull: count+1, mask<={mask[DEPTH-2:0],1};
//    pull&~push: count-1, mask>>1; both or neither: unchanged.
//  - Latency: grant/push/pull combinational same cycle; count/mask/full/empty
//    reflect it next cycle. Invariant: mask_o == (1<<count_o)-1.
//  - Reset asserted mid-operation: immediate return to reset values, no drain.
// CONFIGURATION
//  - STATUS_VECTOR_CTRL_STATS_EN defined: hwm_o <= max(hwm_o, next count) each
//    cycle; stall_o increments (saturating 16'hFFFF) each RUN cycle with
//    |req_i & ~push_o. Both cleared only by reset.
//  - Not defined: hwm_o and stall_o tied to 0, no stats registers built.
// TESTING
//  1 Reset, en_i=0, req_i=4'hF 5 cycles -> gnt_o=0, count_o=0, mask_o=8'h00.
//  2 en_i, req_i=4'hF held 4 cycles -> grants 0001,0010,0100,1000; count_o=4,
//    mask_o=8'h0F.
//  3 Fill to 8 (full_o=1), req_i=1 no commit -> push_o=0, stall_o +1/cycle;
//    add commit_i -> push_o=pull_o=1, count_o stays 8.
//  4 Empty, req_i=4'h2 and commit_i same cycle -> gnt_o=0010, pull_o=0,
//    count_o=1 next cycle.
//  5 count_o=5, flush_i with req_i=4'hF -> no grant; busy_o=1, pull_o 5 cycles,
//    then IDLE, empty_o=1, hwm_o=5 (stats build).
//  6 Assert arst_n_i low at count_o=3 mid-FLUSH -> all outputs at reset values.

Source files
------------

// File: rtl/status_vector_ctrl.sv
// -----------------------------------------------------------------------------
// status_vector_ctrl
//   Sequencer for a DEPTH-entry status valid vector. Arbitrates REQS push
//   requesters round-robin into at most one push per cycle, qualifies commit
//   pulls of the head entry, and owns occupancy (count, full/empty, thermometer
//   tail mask). A small FSM (IDLE/RUN/FLUSH) handles enable and drain.
//
//   Optional statistics (high-water mark, refused-push stall counter) are built
//   only when the macro STATUS_VECTOR_CTRL_STATS_EN is defined; otherwise
//   hwm_o and stall_o are tied to 0.
//
// Ports
//   clk_i     in   1      clock, rising edge
//   arst_n_i  in   1      asynchronous active-low reset
//   en_i      in   1      leave IDLE and start accepting traffic
//   req_i     in   REQS   push request per requester
//   value_i   in   REQS   status bit offered by each requester
//   gnt_o     out  REQS   one-hot grant (combinational)
//   commit_i  in   1      request to pull the head entry
//   flush_i   in   1      start drain of all entries (RUN only)
//   push_o    out  1      push to status vector (combinational)
//   pull_o    out  1      pull from status vector (combinational)
//   value_o   out  1      value of granted requester, 0 when no grant
//   mask_o    out  DEPTH  registered thermometer, bit i=1 iff entry i occupied
//   count_o   out  CW     registered occupancy 0..DEPTH
//   full_o    out  1      count_o == DEPTH
//   empty_o   out  1      count_o == 0
//   busy_o    out  1      1 while draining (FLUSH)
//   hwm_o     out  CW     occupancy high-water mark (stats build)
//   stall_o   out  16     saturating count of refused push cycles (stats build)
// -----------------------------------------------------------------------------
module status_vector_ctrl #(
    parameter int DEPTH = 8,
    parameter int REQS  = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              en_i,
    input  logic [REQS-1:0]   req_i,
    input  logic [REQS-1:0]   value_i,
    output logic [REQS-1:0]   gnt_o,
    input  logic              commit_i,
    input  logic              flush_i,
    output logic              push_o,
    output logic              pull_o,
    output logic              value_o,
    output logic [DEPTH-1:0]  mask_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              busy_o,
    output logic [CW-1:0]     hwm_o,
    output logic [15:0]       stall_o
);

    localparam int PW = (REQS > 1) ? $clog2(REQS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   sel_idx;
    logic            sel_found;
    logic            any_req;
    logic [CW-1:0]   count_nxt;
    logic [DEPTH-1:0] mask_nxt;

    assign any_req = |req_i;
    assign full_o  = (count_o == CW'(DEPTH));
    assign empty_o = (count_o == '0);

    // Round-robin search: first asserted request at index >= rr_ptr, wrapping.
    always_comb begin
        int idx;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = 0; k < REQS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= REQS) idx = idx - REQS;
            if (!sel_found && req_i[idx]) begin
                sel_found = 1'b1;
                sel_idx   = PW'(idx);
            end
        end
    end

    // Next-state and combinational handshake outputs.
    always_comb begin
        state_nxt = state;
        gnt_o     = '0;
        push_o    = 1'b0;
        pull_o    = 1'b0;
        busy_o    = 1'b0;
        case (state)
            IDLE: begin
                if (en_i) state_nxt = RUN;
            end
            RUN: begin
                pull_o = commit_i & ~empty_o;
                if (flush_i) begin
                    // Flush takes priority: nothing is granted this cycle.
                    state_nxt = FLUSH;
                end else if (sel_found && (!full_o || pull_o)) begin
                    push_o         = 1'b1;
                    gnt_o[sel_idx] = 1'b1;
                end
            end
            FLUSH: begin
                busy_o = 1'b1;
                pull_o = ~empty_o;
                if (empty_o) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign value_o = push_o & value_i[sel_idx];

    // Occupancy update; push and pull together leave the vector length unchanged.
    always_comb begin
        count_nxt = count_o;
        mask_nxt  = mask_o;
        if (push_o && !pull_o) begin
            count_nxt = count_o + 1'b1;
            mask_nxt  = {mask_o[DEPTH-2:0], 1'b1};
        end else if (pull_o && !push_o) begin
            count_nxt = count_o - 1'b1;
            mask_nxt  = mask_o >> 1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            count_o <= '0;
            mask_o  <= '0;
        end else begin
            state   <= state_nxt;
            count_o <= count_nxt;
            mask_o  <= mask_nxt;
            if (push_o) begin
                rr_ptr <= (sel_idx == PW'(REQS - 1)) ? '0 : sel_idx + 1'b1;
            end
        end
    end

`ifdef STATUS_VECTOR_CTRL_STATS_EN
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            hwm_o   <= '0;
            stall_o <= '0;
        end else begin
            if (count_nxt > hwm_o) hwm_o <= count_nxt;
            if (state == RUN && any_req && !push_o && stall_o != 16'hFFFF) begin
                stall_o <= stall_o + 16'd1;
            end
        end
    end
`else
    assign hwm_o   = '0;
    assign stall_o = '0;
`endif

endmodule

// File: tb/tb_status_vector_ctrl.sv
// -----------------------------------------------------------------------------
// tb_status_vector_ctrl
//   Directed bench for status_vector_ctrl (DEPTH=8, REQS=4). Inputs change
//   1 time unit after a rising edge; combinational outputs are checked 1 unit
//   later, registered outputs right after the following edge.
// -----------------------------------------------------------------------------
module tb_status_vector_ctrl;

    localparam int DEPTH = 8;
    localparam int REQS  = 4;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef STATUS_VECTOR_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             arst_n_i;
    logic             en_i;
    logic [REQS-1:0]  req_i;
    logic [REQS-1:0]  value_i;
    logic [REQS-1:0]  gnt_o;
    logic             commit_i;
    logic             flush_i;
    logic             push_o;
    logic             pull_o;
    logic             value_o;
    logic [DEPTH-1:0] mask_o;
    logic [CW-1:0]    count_o;
    logic             full_o;
    logic             empty_o;
    logic             busy_o;
    logic [CW-1:0]    hwm_o;
    logic [15:0]      stall_o;

    int n_tests = 0;
    int n_fail  = 0;

    status_vector_ctrl #(.DEPTH(DEPTH), .REQS(REQS)) dut (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .en_i     (en_i),
        .req_i    (req_i),
        .value_i  (value_i),
        .gnt_o    (gnt_o),
        .commit_i (commit_i),
        .flush_i  (flush_i),
        .push_o   (push_o),
        .pull_o   (pull_o),
        .value_o  (value_o),
        .mask_o   (mask_o),
        .count_o  (count_o),
        .full_o   (full_o),
        .empty_o  (empty_o),
        .busy_o   (busy_o),
        .hwm_o    (hwm_o),
        .stall_o  (stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        arst_n_i = 1'b0;
        en_i     = 1'b0;
        req_i    = '0;
        commit_i = 1'b0;
        flush_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 arst_n_i = 1'b1;
    endtask

    // Enable and push five entries with all requesters active.
    task automatic fill_five();
        en_i = 1'b1;
        tick();
        en_i  = 1'b0;
        req_i = 4'hF;
        repeat (5) tick();
        req_i = 4'h0;
    endtask

    logic [REQS-1:0] exp_gnt [4];

    initial begin
        exp_gnt[0] = 4'b0001;
        exp_gnt[1] = 4'b0010;
        exp_gnt[2] = 4'b0100;
        exp_gnt[3] = 4'b1000;
        value_i = 4'b1010;

        // 1: idle after reset ignores requests
        do_reset();
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full",  32'(full_o),  32'd0);
        check("rst_hwm",   32'(hwm_o),   32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        req_i = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("idle_gnt",  32'(gnt_o),  32'd0);
            check("idle_push", 32'(push_o), 32'd0);
            tick();
        end
        check("idle_count", 32'(count_o), 32'd0);
        check("idle_mask",  32'(mask_o),  32'h00);

        // 2: round-robin grants
        req_i = 4'h0;
        en_i  = 1'b1;
        tick();
        en_i  = 1'b0;
        req_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_gnt", 32'(gnt_o), 32'(exp_gnt[i]));
            check("rr_value", 32'(value_o), 32'(value_i[i]));
            tick();
        end
        check("rr_count", 32'(count_o), 32'd4);
        check("rr_mask",  32'(mask_o),  32'h0F);

        // 3: fill to full, refused pushes, then push+pull together
        repeat (4) tick();
        check("full_count", 32'(count_o), 32'd8);
        check("full_mask",  32'(mask_o),  32'hFF);
        check("full_flag",  32'(full_o),  32'd1);
        req_i = 4'h1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("full_push", 32'(push_o), 32'd0);
            check("full_gnt",  32'(gnt_o),  32'd0);
            tick();
        end
        check("stall_cnt", 32'(stall_o), STATS ? 32'd2 : 32'd0);
        commit_i = 1'b1;
        #1;
        check("both_push", 32'(push_o), 32'd1);
        check("both_pull", 32'(pull_o), 32'd1);
        check("both_gnt",  32'(gnt_o),  32'b0001);
        tick();
        check("both_count", 32'(count_o), 32'd8);
        check("both_full",  32'(full_o),  32'd1);

        // 4: drain by commits, then push+commit on empty
        req_i = 4'h0;
        repeat (8) tick();
        check("drain_count", 32'(count_o), 32'd0);
        check("drain_empty", 32'(empty_o), 32'd1);
        req_i = 4'h2;
        #1;
        check("empty_gnt",   32'(gnt_o),   32'b0010);
        check("empty_pull",  32'(pull_o),  32'd0);
        check("empty_push",  32'(push_o),  32'd1);
        check("empty_value", 32'(value_o), 32'd1);
        tick();
        req_i    = 4'h0;
        commit_i = 1'b0;
        check("empty_count", 32'(count_o), 32'd1);
        check("empty_mask",  32'(mask_o),  32'h01);

        // 5: flush from five entries
        do_reset();
        fill_five();
        check("pre_flush_count", 32'(count_o), 32'd5);
        check("pre_flush_mask",  32'(mask_o),  32'h1F);
        req_i   = 4'hF;
        flush_i = 1'b1;
        #1;
        check("flush_gnt",  32'(gnt_o),  32'd0);
        check("flush_push", 32'(push_o), 32'd0);
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("drain_busy", 32'(busy_o), 32'd1);
            check("drain_pull", 32'(pull_o), 32'd1);
            check("drain_gnt",  32'(gnt_o),  32'd0);
            tick();
        end
        #1;
        check("flush_end_busy",  32'(busy_o),  32'd1);
        check("flush_end_pull",  32'(pull_o),  32'd0);
        check("flush_end_empty", 32'(empty_o), 32'd1);
        tick();
        check("post_flush_busy", 32'(busy_o), 32'd0);
        check("post_flush_gnt",  32'(gnt_o),  32'd0);
        check("post_flush_hwm",  32'(hwm_o),  STATS ? 32'd5 : 32'd0);
        req_i = 4'h0;

        // 6: asynchronous reset in the middle of a flush
        do_reset();
        fill_five();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        repeat (2) tick();
        check("mid_flush_count", 32'(count_o), 32'd3);
        check("mid_flush_busy",  32'(busy_o),  32'd1);
        #2 arst_n_i = 1'b0;
        #1;
        check("arst_count", 32'(count_o), 32'd0);
        check("arst_mask",  32'(mask_o),  32'h00);
        check("arst_empty", 32'(empty_o), 32'd1);
        check("arst_busy",  32'(busy_o),  32'd0);
        check("arst_pull",  32'(pull_o),  32'd0);
        check("arst_hwm",   32'(hwm_o),   32'd0);
        check("arst_stall", 32'(stall_o), 32'd0);
        #10 arst_n_i = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
